div_iter: RTL and testbench
===========================

# div_iter

Parametrised iterative restoring divider, the next generation of the execute-stage multi-cycle divide unit. Computes quotient and remainder of a WIDTH-bit signed or unsigned division, one quotient bit per cycle. Uses a valid/ready handshake on both sides, with a registered result held until consumed. Adds a one-cycle divide-by-zero path and optional leading-zero early termination. Sits beside the multiplier in the execute stage; `busy` feeds the pipeline stall logic.

## Interface
- `WIDTH`, 32, operand width in bits; must be at least 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort; has priority over all other inputs except reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  high only in IDLE.
- `sign`  in  1  1 = signed (two's complement), 0 = unsigned; sampled at accept.
- `a`  in  WIDTH  dividend.
- `b`  in  WIDTH  divisor.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_by_zero`  out  1  flag registered with the result.
- `busy`  out  1  state != IDLE.

## Operation
- States are IDLE, CALC and DONE.
- Reset state: IDLE. Reset values: `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, `busy`=0.
- IDLE: `in_ready`=1.
  - When `in_valid` is high, the operands are accepted.
  - On accept, the block latches the sign flags `a_neg` = `sign`&`a`[MSB] and `b_neg` = `sign`&`b`[MSB], plus |a| and |b|.
- `b`==0 on accept: go straight to DONE with `quotient`=all ones, `remainder`=`a` (unmodified), `div_by_zero`=1.
- Otherwise go to CALC with iteration counter = WIDTH, or WIDTH − lz(|a|) if early-out is enabled.
- CALC, each cycle:
  - Trial subtract: partial remainder (WIDTH+1 bits) minus |b| (WIDTH+1 bits).
  - If there is no borrow, keep the difference and shift in quotient bit 1; otherwise keep the partial remainder and shift in 0.
  - Decrement the counter.
- CALC, on the last iteration: register the fixed-up result and go to DONE.
  - `quotient` is negated if `a_neg`^`b_neg`.
  - `remainder` is negated if `a_neg`, so the remainder takes the dividend's sign.
- DONE: `out_valid`=1. When `out_ready` is high, go to IDLE and clear `out_valid`. Outputs hold their values until the next result.
- Signed overflow, MIN / −1: `quotient`=MIN and `remainder`=0, falling out of modulo-2^WIDTH negation. No flag is raised.
- Unsigned mode treats the MSB as magnitude; no fix-up is applied.
- `flush` in any state: go to IDLE next edge and drop `out_valid`. Registered `quotient` and `remainder` keep their old values. `in_valid` in the same cycle as `flush` is not accepted.
- Reset mid-operation clears the state asynchronously; no partial result is ever presented.

## Timing
- Accept edge E0: `busy` rises after E0.
- Normal latency: `out_valid` rises after edge E_N, where N = number of iterations (WIDTH, or the early-out count).
- Divide-by-zero latency: `out_valid` rises after E1, i.e. 1 cycle.
- Back-to-back: a DONE→IDLE handshake at edge Ek allows a new accept at Ek+1. There is no same-cycle accept of new operands while DONE.
- Throughput without early-out: one divide per WIDTH+2 cycles, assuming `out_ready` is tied high.
- `in_ready` and `busy` are decoded from the state register; no input-to-output combinational path exists.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - On accept, |a| is pre-shifted left by lz(|a|) and the counter is loaded with WIDTH − lz(|a|).
  - If |a|==0: DONE after 1 cycle with `quotient`=0, `remainder`=0.
  - Latency is data-dependent, from 1 to WIDTH.
- Undefined: the leading-zero logic is absent and every non-zero-divisor operation takes exactly WIDTH CALC cycles.
- Results are bit-identical in both builds.

## Structure
- Package `div_pkg` holds:
  - the state enum `div_state_t` (IDLE, CALC, DONE);
  - `DIV_DEFAULT_WIDTH` = 32;
  - the counter-width function clog2(WIDTH+1).
- Sub-module `div_lzc`: parametrised WIDTH-bit leading-zero counter with output width clog2(WIDTH+1). It is instantiated only under `DIV_EARLY_OUT_EN`.
- All datapath registers (partial remainder, quotient shift register, |b|, sign flags, counter) live in `div_iter`.

## Test plan
- Unsigned, WIDTH=32: a=100, b=7 → `quotient`=14, `remainder`=2. `out_valid` 32 cycles after accept (no early-out), 7 cycles with early-out.
- Signed: a=−7 (0xFFFFFFF9), b=2 → `quotient`=−3 (0xFFFFFFFD), `remainder`=−1 (0xFFFFFFFF); a=7, b=−2 → `quotient`=−3, `remainder`=1.
- Overflow and zero: a=0x80000000, b=0xFFFFFFFF signed → `quotient`=0x80000000, `remainder`=0. a=5, b=0 → `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1, `out_valid` 1 cycle after accept.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout. Release `out_ready` → `in_ready`=1 the next cycle.
- Flush and reset: assert `flush` at CALC cycle 10 → IDLE next cycle, no `out_valid`, next divide correct. Assert `rst_n`=0 mid-CALC → all outputs at reset values immediately.
- Random sweep, WIDTH ∈ {8,32,64}, both `sign` modes, ±`DIV_EARLY_OUT_EN`, random `out_ready` → every result matches the reference model q=a/b, r=a%b (truncating).

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state type, default width and counter sizing for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DEFAULT_WIDTH = 32;

  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_lzc.sv
// div_lzc: leading-zero counter; an all-zero input reports WIDTH.
module div_lzc import div_pkg::*; #(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]             val_i,
  output logic [div_cnt_w(WIDTH)-1:0]  lz_o
);

  localparam int CW = div_cnt_w(WIDTH);

  logic found;

  always_comb begin
    lz_o  = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (val_i[i]) begin
        found = 1'b1;
      end else if (!found) begin
        lz_o = lz_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, one quotient bit per cycle, signed/unsigned.
// Optional leading-zero early termination is built when DIV_EARLY_OUT_EN is defined.
module div_iter import div_pkg::*; #(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output div_state_t       dbg_state_o
);

  localparam int CW = div_cnt_w(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid holds until out_ready, flush drops both sides.
  div_state_t       state_q;
  logic [WIDTH-1:0] rem_q, dvd_q, babs_q, quo_q, rmd_q;
  logic [CW-1:0]    cnt_q;
  logic             a_neg_q, b_neg_q, dbz_q, out_valid_q, dbz_out_q;

  logic             a_neg_w, b_neg_w;
  logic [WIDTH-1:0] a_abs, b_abs, dvd_init;
  logic [CW-1:0]    cnt_init;

  assign a_neg_w = sign & a[WIDTH-1];
  assign b_neg_w = sign & b[WIDTH-1];
  assign a_abs   = a_neg_w ? -a : a;
  assign b_abs   = b_neg_w ? -b : b;

`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0] lz;

  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .val_i (a_abs),
    .lz_o  (lz)
  );

  // A zero dividend still spends one iteration so its latency matches the shortest case.
  assign dvd_init = a_abs << lz;
  assign cnt_init = (a_abs == '0) ? CW'(1) : CW'(WIDTH) - lz;
`else
  assign dvd_init = a_abs;
  assign cnt_init = CW'(WIDTH);
`endif

  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_d, dvd_d, q_fix, r_fix;

  // The dividend register doubles as the quotient shift register.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, babs_q};
  assign q_bit   = ~diff[WIDTH];
  assign rem_d   = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_d   = {dvd_q[WIDTH-2:0], q_bit};
  assign q_fix   = (a_neg_q ^ b_neg_q) ? -dvd_d : dvd_d;
  assign r_fix   = a_neg_q ? -rem_d : rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      babs_q      <= '0;
      cnt_q       <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      quo_q       <= '0;
      rmd_q       <= '0;
      dbz_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_neg_q <= a_neg_w;
            b_neg_q <= b_neg_w;
            babs_q  <= b_abs;
            rem_q   <= '0;
            state_q <= CALC;
            if (b == '0) begin
              dbz_q <= 1'b1;
              dvd_q <= a;
              cnt_q <= CW'(1);
            end else begin
              dbz_q <= 1'b0;
              dvd_q <= dvd_init;
              cnt_q <= cnt_init;
            end
          end
        end
        CALC: begin
          if (dbz_q) begin
            quo_q       <= '1;
            rmd_q       <= dvd_q;
            dbz_out_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              quo_q       <= q_fix;
              rmd_q       <= r_fix;
              dbz_out_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random checks of div_iter (WIDTH=32) against a reference model.
module tb_div_iter;
  import div_pkg::*;

  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             sign = 1'b0;
  logic             out_ready = 1'b0;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             in_ready, out_valid, div_by_zero, busy;
  logic [W-1:0]     quotient, remainder;
  div_state_t       dbg_state;

  logic [2*W:0]     exp_q[$];
  int               compared = 0;
  int               mismatched = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int lz_of(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    logic [W-1:0] aa;
    int           eo;
    aa = (s && av[W-1]) ? -av : av;
    eo = (aa == '0) ? 1 : W - lz_of(aa);
    if (bv == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
    return eo;
`else
    return (eo > 0) ? W : W;
`endif
  endfunction

  function automatic logic [2*W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    logic [W-1:0] q, r;
    if (bv == '0) return {1'b1, {W{1'b1}}, av};
    if (s) begin
      if (av == {1'b1, {(W-1){1'b0}}} && bv == {W{1'b1}}) begin
        q = av;
        r = '0;
      end else begin
        q = $signed(av) / $signed(bv);
        r = $signed(av) % $signed(bv);
      end
    end else begin
      q = av / bv;
      r = av % bv;
    end
    return {1'b0, q, r};
  endfunction

  // Driver: one full divide; starts and ends just after a falling edge.
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, input int hold);
    int           lat;
    logic [2*W:0] e;
    logic [W-1:0] q_hold, r_hold;
    exp_q.push_back(model(av, bv, s));
    check("in_ready_idle", in_ready, 1);
    a = av; b = bv; sign = s; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
    check("busy_after_accept", busy, 1);
    check("in_ready_while_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    check("latency", lat, exp_lat(av, bv, s));
    q_hold = quotient;
    r_hold = remainder;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient_stable", quotient, q_hold);
      check("bp_remainder_stable", remainder, r_hold);
    end
    e = exp_q.pop_front();
    check("div_by_zero", div_by_zero, e[2*W]);
    check("quotient", quotient, e[2*W-1:W]);
    check("remainder", remainder, e[W-1:0]);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_handshake", in_ready, 1);
    check("out_valid_dropped", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         seen;

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state", dbg_state, IDLE);

    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_div(32'd5, 32'd0, 1'b0, 0);
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, 0);
    do_div(32'd0, 32'd9, 1'b1, 0);
    do_div(32'd1, 32'd1, 1'b0, 0);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_div(32'd1000, 32'd33, 1'b0, 10);

    // Flush in the tenth CALC cycle of a full-length divide
    a = 32'hFFFF_0000; b = 32'd3; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check("flush_state_idle", dbg_state, IDLE);
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_keeps_quotient", quotient, 32'd30);
    check("flush_keeps_remainder", remainder, 32'd10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_result_after_flush", seen, 0);

    // in_valid together with flush is not accepted
    a = 32'd10; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", busy, 0);

    do_div(32'd1234567, 32'd89, 1'b0, 0);

    // Asynchronous reset in the middle of CALC
    a = 32'hDEAD_BEEF; b = 32'd17; sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_by_zero", div_by_zero, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(32'hFFFF_FF9C, 32'd7, 1'b1, 2);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = W'($urandom_range(0, 255));
        2:       ra = 32'h8000_0000;
        default: ra = -W'($urandom_range(0, 1000));
      endcase
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = W'($urandom_range(1, 15));
        3:       rb = -W'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      do_div(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
